// File: rtl/ifetch_bp.sv
// ifetch_bp: instruction-fetch unit with a 2-bit branch history table and a
// decoupling instruction queue between the I-cache and decode/issue.
//
// Each cycle in REQ it requests one instruction at pc_q, pre-decodes the
// returned word (JAL / BRANCH / JALR) to pick the next PC and pushes
// {pc, inst, pred_taken} into a circular queue. Fetch pauses while the
// queue is full (HOLD) or while a JALR target is unresolved (JSTALL).
//
// Optional feature macro: IFETCH_BP_EN
//   defined   : BRANCH prediction from a 2^BHT_IDX_W x 2-bit counter table,
//               trained by ROB commits on bp_upd_*.
//   undefined : no table; BRANCH is always predicted not-taken and the
//               bp_upd_* inputs are ignored. JAL still redirects.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable, low freezes all state
//   ic_req/ic_addr      fetch request and address to the I-cache
//   ic_abort            drop outstanding request (mirrors flush)
//   ic_valid/ic_inst    one-cycle response strobe and instruction word
//   flush/flush_pc      redirect from the ROB
//   bp_upd_*            committed conditional branch outcome
//   jalr_done/target    resolved JALR target
//   iq_*                queue head (valid/ready handshake) and occupancy
module ifetch_bp #(
  parameter int          BHT_IDX_W    = 7,
  parameter int          IQ_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic                    ic_req,
  output logic [31:0]             ic_addr,
  output logic                    ic_abort,
  input  logic                    ic_valid,
  input  logic [31:0]             ic_inst,
  input  logic                    flush,
  input  logic [31:0]             flush_pc,
  input  logic                    bp_upd_valid,
  input  logic [31:0]             bp_upd_pc,
  input  logic                    bp_upd_taken,
  input  logic                    jalr_done,
  input  logic [31:0]             jalr_target,
  output logic                    iq_valid,
  input  logic                    iq_ready,
  output logic [31:0]             iq_pc,
  output logic [31:0]             iq_inst,
  output logic                    iq_pred_taken,
  output logic [IQ_DEPTH_LOG:0]   iq_count
);

  localparam int DEPTH = 1 << IQ_DEPTH_LOG;
  localparam int CW    = IQ_DEPTH_LOG + 1;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_JSTALL} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [IQ_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d, count_nxt;
  logic [31:0]             q_pc_q   [DEPTH];
  logic [31:0]             q_pc_d   [DEPTH];
  logic [31:0]             q_inst_q [DEPTH];
  logic [31:0]             q_inst_d [DEPTH];
  logic                    q_pred_q [DEPTH];
  logic                    q_pred_d [DEPTH];

  logic        push, pop;
  logic        bht_pred;
  logic        pred;
  logic [31:0] next_pc;
  logic [31:0] j_imm, b_imm;

  // ---------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------
`ifdef IFETCH_BP_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_upd_bits;

  assign upd_idx         = bp_upd_pc[BHT_IDX_W+1:2];
  assign unused_upd_bits = ^{bp_upd_pc[31:BHT_IDX_W+2], bp_upd_pc[1:0]};
  // Read uses the registered table, so a same-cycle update at the same
  // index is not seen by this cycle's prediction.
  assign bht_pred        = bht_q[pc_q[BHT_IDX_W+1:2]][1];

  always_comb begin
    bht_d = bht_q;
    if (rdy && bp_upd_valid) begin
      if (bp_upd_taken && bht_q[upd_idx] != 2'b11)
        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      else if (!bp_upd_taken && bht_q[upd_idx] != 2'b00)
        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_upd_bits;
  assign unused_upd_bits = ^{bp_upd_valid, bp_upd_pc, bp_upd_taken};
  assign bht_pred        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Pre-decode of the returning instruction
  // ---------------------------------------------------------------------
  assign j_imm = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20],
                  ic_inst[30:21], 1'b0};
  assign b_imm = {{19{ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25],
                  ic_inst[11:8], 1'b0};

  always_comb begin
    pred    = 1'b0;
    next_pc = pc_q + 32'd4;
    case (ic_inst[6:0])
      OP_JAL: begin
        pred    = 1'b1;
        next_pc = pc_q + j_imm;
      end
      OP_BR: begin
        pred = bht_pred;
        if (bht_pred) next_pc = pc_q + b_imm;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Fetch FSM and queue control
  // ---------------------------------------------------------------------
  assign push      = rdy && !flush && (state_q == S_REQ) && ic_valid;
  assign pop       = rdy && !flush && iq_valid && iq_ready;
  assign count_nxt = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    q_pred_d = q_pred_q;
    if (rdy) begin
      if (flush) begin
        state_d  = S_REQ;
        pc_d     = flush_pc;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        count_d = count_nxt;
        if (push) begin
          q_pc_d[wr_ptr_q]   = pc_q;
          q_inst_d[wr_ptr_q] = ic_inst;
          q_pred_d[wr_ptr_q] = pred;
          wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case (state_q)
          S_REQ: begin
            if (push) begin
              pc_d = next_pc;
              if (ic_inst[6:0] == OP_JALR)       state_d = S_JSTALL;
              else if (count_nxt == CW'(DEPTH))  state_d = S_HOLD;
            end
          end
          S_HOLD: begin
            if (count_nxt < CW'(DEPTH)) state_d = S_REQ;
          end
          S_JSTALL: begin
            // A JALR that filled the queue must not resume straight into
            // REQ, or the next response would overflow it.
            if (jalr_done) begin
              pc_d    = jalr_target;
              state_d = (count_nxt == CW'(DEPTH)) ? S_HOLD : S_REQ;
            end
          end
          default: state_d = S_REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
        q_pred_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_pc_q   <= q_pc_d;
      q_inst_q <= q_inst_d;
      q_pred_q <= q_pred_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ic_req        = (state_q == S_REQ);
  assign ic_addr       = pc_q;
  assign ic_abort      = flush;
  assign iq_valid      = (count_q != '0);
  assign iq_pc         = q_pc_q[rd_ptr_q];
  assign iq_inst       = q_inst_q[rd_ptr_q];
  assign iq_pred_taken = iq_valid & q_pred_q[rd_ptr_q];
  assign iq_count      = count_q;

endmodule

// File: tb/tb_ifetch_bp.sv
module tb_ifetch_bp;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ic_req, ic_abort, ic_valid;
  logic [31:0] ic_addr, ic_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        bp_upd_valid, bp_upd_taken;
  logic [31:0] bp_upd_pc;
  logic        jalr_done;
  logic [31:0] jalr_target;
  logic        iq_valid, iq_ready, iq_pred_taken;
  logic [31:0] iq_pc, iq_inst;
  logic [2:0]  iq_count;

  int checks = 0;
  int errors = 0;

`ifdef IFETCH_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JAL  = 32'h0200006F;  // jal x0, +0x20
  localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0,x0,-8
  localparam logic [31:0] JALR = 32'h00008067;  // jalr x0,0(x1)

  always #5 clk = ~clk;

  ifetch_bp dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_abort(ic_abort),
    .ic_valid(ic_valid), .ic_inst(ic_inst),
    .flush(flush), .flush_pc(flush_pc),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
    .jalr_done(jalr_done), .jalr_target(jalr_target),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_pc(iq_pc), .iq_inst(iq_inst),
    .iq_pred_taken(iq_pred_taken), .iq_count(iq_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] inst);
    ic_valid = 1'b1;
    ic_inst  = inst;
    tick();
    ic_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush    = 1'b0;
  endtask

  task automatic pop1();
    iq_ready = 1'b1;
    tick();
    iq_ready = 1'b0;
  endtask

  task automatic bp_upd(input logic taken, input int n);
    for (int k = 0; k < n; k++) begin
      bp_upd_valid = 1'b1;
      bp_upd_pc    = 32'h40;
      bp_upd_taken = taken;
      tick();
    end
    bp_upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; ic_valid = 1'b0; ic_inst = '0;
    flush = 1'b0; flush_pc = '0; bp_upd_valid = 1'b0; bp_upd_pc = '0;
    bp_upd_taken = 1'b0; jalr_done = 1'b0; jalr_target = '0; iq_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ic_req", 32'(ic_req), 32'd1);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_iq_valid", 32'(iq_valid), 32'd0);
    chk("rst_iq_count", 32'(iq_count), 32'd0);
    chk("rst_pred", 32'(iq_pred_taken), 32'd0);

    // Sequential fetch of addi at 0,4,8
    fetch(ADDI);
    chk("seq0_addr", ic_addr, 32'h4);
    chk("seq0_valid", 32'(iq_valid), 32'd1);
    chk("seq0_count", 32'(iq_count), 32'd1);
    fetch(ADDI);
    chk("seq1_addr", ic_addr, 32'h8);
    fetch(ADDI);
    chk("seq2_addr", ic_addr, 32'hC);
    chk("seq2_count", 32'(iq_count), 32'd3);
    chk("head0_pc", iq_pc, 32'h0);
    chk("head0_inst", iq_inst, ADDI);
    chk("head0_pred", 32'(iq_pred_taken), 32'd0);
    pop1();
    chk("head1_pc", iq_pc, 32'h4);
    pop1();
    chk("head2_pc", iq_pc, 32'h8);
    pop1();
    chk("drain_count", 32'(iq_count), 32'd0);
    chk("drain_valid", 32'(iq_valid), 32'd0);

    // JAL at 0x10, +0x20
    redirect(32'h10);
    chk("fl10_addr", ic_addr, 32'h10);
    fetch(JAL);
    chk("jal_addr", ic_addr, 32'h30);
    chk("jal_pc", iq_pc, 32'h10);
    chk("jal_pred", 32'(iq_pred_taken), 32'd1);
    pop1();

    // BRANCH at 0x40, counter starts weakly not-taken
    redirect(32'h40);
    fetch(BEQ);
    chk("br0_addr", ic_addr, 32'h44);
    chk("br0_pred", 32'(iq_pred_taken), 32'd0);
    pop1();
    bp_upd(1'b1, 3);  // 01 -> 11, third update checks top saturation
    redirect(32'h40);
    fetch(BEQ);
    chk("br1_addr", ic_addr, BP ? 32'h38 : 32'h44);
    chk("br1_pred", 32'(iq_pred_taken), BP ? 32'd1 : 32'd0);
    pop1();
    bp_upd(1'b0, 4);  // saturate at 00
    bp_upd(1'b1, 2);  // 00 -> 10
    redirect(32'h40);
    // Same-cycle not-taken update: prediction still uses the old counter 10
    bp_upd_valid = 1'b1; bp_upd_pc = 32'h40; bp_upd_taken = 1'b0;
    fetch(BEQ);
    bp_upd_valid = 1'b0;
    chk("br2_addr", ic_addr, BP ? 32'h38 : 32'h44);
    chk("br2_pred", 32'(iq_pred_taken), BP ? 32'd1 : 32'd0);
    pop1();
    redirect(32'h40);
    fetch(BEQ);  // counter now 01
    chk("br3_addr", ic_addr, 32'h44);
    chk("br3_pred", 32'(iq_pred_taken), 32'd0);
    pop1();

    // jalr_done outside JSTALL is ignored
    redirect(32'h50);
    jalr_done = 1'b1; jalr_target = 32'h999;
    tick();
    jalr_done = 1'b0;
    chk("jalr_ign_addr", ic_addr, 32'h50);

    // JALR stall
    fetch(JALR);
    chk("jalr_req0", 32'(ic_req), 32'd0);
    fetch(ADDI);  // response while stalled is not a request; ignored
    chk("jalr_req1", 32'(ic_req), 32'd0);
    chk("jalr_count", 32'(iq_count), 32'd1);
    jalr_done = 1'b1; jalr_target = 32'h100;
    tick();
    jalr_done = 1'b0;
    chk("jalr_addr", ic_addr, 32'h100);
    chk("jalr_req2", 32'(ic_req), 32'd1);
    chk("jalr_inst", iq_inst, JALR);
    pop1();

    // Fill the queue -> HOLD
    for (int k = 0; k < 4; k++) fetch(ADDI);
    chk("hold_count", 32'(iq_count), 32'd4);
    chk("hold_req", 32'(ic_req), 32'd0);
    chk("hold_addr", ic_addr, 32'h110);
    fetch(ADDI);
    chk("hold_ign", 32'(iq_count), 32'd4);
    pop1();
    chk("resume_req", 32'(ic_req), 32'd1);
    chk("resume_addr", ic_addr, 32'h110);
    chk("resume_count", 32'(iq_count), 32'd3);
    chk("resume_head", iq_pc, 32'h104);

    // rdy=0 freezes everything
    rdy = 1'b0; iq_ready = 1'b1;
    fetch(ADDI);
    rdy = 1'b1; iq_ready = 1'b0;
    chk("frz_count", 32'(iq_count), 32'd3);
    chk("frz_addr", ic_addr, 32'h110);
    chk("frz_head", iq_pc, 32'h104);

    // Flush with concurrent ic_valid and pop on a 3-entry queue
    flush = 1'b1; flush_pc = 32'h200; iq_ready = 1'b1;
    ic_valid = 1'b1; ic_inst = ADDI;
    #1;
    chk("abort", 32'(ic_abort), 32'd1);
    tick();
    flush = 1'b0; iq_ready = 1'b0; ic_valid = 1'b0;
    chk("fl_count", 32'(iq_count), 32'd0);
    chk("fl_valid", 32'(iq_valid), 32'd0);
    chk("fl_addr", ic_addr, 32'h200);
    chk("fl_req", 32'(ic_req), 32'd1);
    chk("fl_abort_lo", 32'(ic_abort), 32'd0);
    fetch(ADDI);
    chk("fl_head", iq_pc, 32'h200);
    chk("fl_count1", 32'(iq_count), 32'd1);

    // Reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_addr", ic_addr, 32'h0);
    chk("rst2_count", 32'(iq_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
